cpu_boot_loader: RTL
====================

Name: cpu_boot_loader

Overview:
- Upstream of the multicycle CPU: streams a program image into the CPU's memory, then releases the CPU.
- While loading, it owns the memory write port and holds the CPU in reset via `cpu_hold`.
- `cpu_hold` gates the PC and IR write enables, and selects the loader on the memory address/data mux.
- The image format is a length word, N program words, then an XOR checksum word.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first program word.
- ADDR_STEP, 4, byte increment per word; matches PC+4.
- MAX_WORDS, 1024, largest accepted N.
- CNT_W, 16, width of the word counter and of `words_loaded`.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high.
- start  input  1  level; begins a new load from IDLE, RUN or ERROR.
- in_valid  input  1  an input word is presented.
- in_ready  output  1  the loader accepts a word this cycle.
- in_data  input  32  stream word (length, program word or checksum).
- mem_addr  output  32  byte address to memory.
- mem_wdata  output  32  write data to memory.
- mem_we  output  1  memory write enable, one-cycle pulse per word.
- cpu_hold  output  1  1 = CPU frozen and loader owns memory.
- done  output  1  image loaded and verified; CPU running.
- error  output  1  length or checksum failure.
- words_loaded  output  CNT_W  program words written so far.
- state_out  output  3  encoded state: IDLE=0, LEN=1, LOAD=2, CHECK=3, RUN=4, ERROR=5.

Behaviour:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-high, named `reset`.
- Reset values: state IDLE, `cpu_hold`=1, `in_ready`=0, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `done`=0, `error`=0, `words_loaded`=0, length register 0, checksum accumulator 0.
- Transfer: occurs on a posedge with `in_valid` && `in_ready`.
  - `in_ready` is combinational from state: 1 in LEN, LOAD and CHECK; 0 otherwise.
  - `in_data` must stay stable while `in_valid` && !`in_ready`.
- IDLE: `start`=1 moves to LEN. `cpu_hold`=1.
- LEN: on transfer, capture N=`in_data` and set acc=`in_data`.
  - N > MAX_WORDS: go to ERROR.
  - N = 0: go to CHECK.
  - Otherwise: go to LOAD with `words_loaded`=0.
- LOAD: on transfer k (k = 0..N-1):
  - Next cycle: `mem_addr`=BASE_ADDR+k*ADDR_STEP, `mem_wdata`=`in_data`, `mem_we`=1 for exactly one cycle (latency 1).
  - acc ^= `in_data`; `words_loaded` increments.
  - After transfer N-1, go to CHECK.
  - Back-to-back transfers give one write per cycle, with no stall.
- CHECK: on transfer, compare `in_data` with acc.
  - Equal: go to RUN.
  - Not equal: go to ERROR.
  - The pending `mem_we` pulse for the last word may be active during the first CHECK cycle; this is legal.
- RUN: `cpu_hold`=0, `done`=1, `mem_we`=0. `start`=1 returns to LEN with `cpu_hold`=1 and `done`=0 on the same edge.
- ERROR: `error`=1, `cpu_hold`=1. It is left only by `start` (goes to LEN and clears `error`) or by `reset`.
- `start` is ignored in LEN, LOAD and CHECK.
- `in_valid` outside LEN, LOAD and CHECK is ignored; no word is consumed.
- Address arithmetic is 32-bit modulo 2^32; wrap-around is not flagged.
- `words_loaded` holds its final value through RUN and ERROR and clears on entry to LOAD.
- Reset mid-load: immediate return to IDLE with `cpu_hold`=1. Memory contents are not restored.
- `cpu_hold` is a registered output, with no glitches between states.

Test Plan:
- Basic load: `reset`, `start`, stream 3, 0x20020005, 0x20030007, 0x00431820, checksum 0x00421821 with continuous `in_valid`.
  - Required: writes to addresses 0, 4, 8 on consecutive cycles.
  - Required: RUN, `done`=1, `cpu_hold`=0, `words_loaded`=3.
- Bad checksum: same stream with checksum 0x00421820.
  - Required: ERROR, `error`=1, `cpu_hold`=1, three writes performed.
  - Then `start`: required LEN with `error`=0.
- Length limits:
  - N=1025 → ERROR immediately, no `mem_we`.
  - N=0 with checksum 0 → RUN with zero writes.
- Backpressure: toggle `in_valid` 1/0 every cycle during LOAD of 4 words.
  - Required: exactly 4 `mem_we` pulses at addresses 0/4/8/12, order preserved.
- Reset mid-LOAD after 2 words: required IDLE, `cpu_hold`=1, `mem_we`=0 asynchronously; a fresh load then succeeds.
- Reload from RUN: assert `start` → `cpu_hold` rises on the same edge, state LEN, `done`=0; also check that `start` in LOAD is ignored.

Source files
------------

// File: rtl/cpu_boot_loader.sv
// Boot loader: streams a length-prefixed, XOR-checksummed program image into
// CPU memory while holding the CPU, then releases it once the checksum verifies.
module cpu_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLen   = 3'd1,
    StLoad  = 3'd2,
    StCheck = 3'd3,
    StRun   = 3'd4,
    StError = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      len_q, len_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             xfer;

  assign in_ready = (state_q == StLen) || (state_q == StLoad) || (state_q == StCheck);
  assign xfer     = in_valid && in_ready;

  // Next-state and datapath updates; status flags derive from the next state so
  // they change on the same edge as the state and are glitch-free registers.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) state_d = StLen;
      end
      StLen: begin
        if (xfer) begin
          len_d = in_data;
          acc_d = in_data;
          if (in_data > MAX_WORDS) begin
            state_d = StError;
          end else if (in_data == 32'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StLoad;
            cnt_d   = '0;
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          // Address is taken from the count of words already written (modulo 2^32).
          addr_d  = BASE_ADDR + (32'(cnt_q) * ADDR_STEP);
          wdata_d = in_data;
          we_d    = 1'b1;
          acc_d   = acc_q ^ in_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if ((32'(cnt_q) + 32'd1) == len_q) state_d = StCheck;
        end
      end
      StCheck: begin
        if (xfer) begin
          if (in_data == acc_q) state_d = StRun;
          else                  state_d = StError;
        end
      end
      StRun, StError: begin
        if (start) state_d = StLen;
      end
      default: state_d = StIdle;
    endcase

    hold_d  = (state_d != StRun);
    done_d  = (state_d == StRun);
    error_d = (state_d == StError);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_we       = we_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = cnt_q;
  assign state_out    = state_q;

endmodule
